floyd_warshall_kernel: RTL and testbench
========================================

Name: floyd_warshall_kernel

Overview:
- All-pairs shortest-path accelerator. Runs the Floyd-Warshall recurrence in place on a 64x64 matrix of signed 32-bit distances.
- The matrix lives in external storage split into 4 banks. Each bank has 2 synchronous single-cycle RAM ports.
- Host control uses a start/done/idle/ready block-level handshake. The kernel sits between a DMA/host wrapper, which loads and unloads the matrix, and the bank RAMs.

Parameters:
- N, 64, matrix dimension.
- DATA_WID, 32, element width (two's complement).
- BANKS, 4, row-block banks; bank b holds rows 16b..16b+15.
- BANK_AW, 10, bank address width; bank address = (row mod 16)*64 + col.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- ap_start  in  1  start request.
- ap_done  out  1  one-cycle completion pulse.
- ap_idle  out  1  high while not running.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- path_B_addressP  out  10  address; bank B in 0..3, port P in 0..1.
- path_B_ceP  out  1  port enable.
- path_B_weP  out  1  write enable, qualified by ceP.
- path_B_dP  out  32  write data.
- path_B_qP  in  32  read data.

Behaviour:
- Reset values (async assert): ap_done=0, ap_ready=0, ap_idle=1, all ce/we=0, all addresses=0, all d=0. FSM goes to IDLE, loop counters clear.
- Reset mid-run aborts immediately. No further RAM accesses; matrix contents are left as-is.
- States:
  - IDLE: ap_idle=1. ap_start=1 sampled at a clock edge moves to RUN, with k=i=j=0.
  - RUN: ap_idle=0. ap_start is ignored.
  - DONE: one cycle. ap_done=ap_ready=1, then return to IDLE.
  - If ap_start is still high in IDLE, a new run begins. A one-cycle ap_start pulse is sufficient.
- RAM model:
  - Read: ce=1, we=0 at edge t; q is valid during the cycle after t and holds until the next read on that port.
  - Write: ce=1, we=1 commits d at the edge.
  - Read and write to the same address in the same cycle returns the old data.
  - The kernel never issues two writes to the same address in one cycle.
- Computation: for k, for i, for j (all 0..63, j innermost):
  - s = path[i][k] + path[k][j], 32-bit wrap-around.
  - If s < path[i][j] (signed, strict), write s to path[i][j]; otherwise no write is required.
- Result must be bit-exact to the sequential in-place loop, including negative entries and negative diagonals.
- path[i][k] is held in a register, read at the start of row i. It is updated whenever the j==k write of that row occurs.
- path[k][j] and path[i][j] are re-read per element. A read issued after a write to the same address must see the new value, so a one-cycle spacing is required.
- Port use: row-i accesses use bank i/16; row-k accesses use bank k/16. At most 2 accesses per bank per cycle. Idle ports hold ce=0.
- Throughput: at least one (i,j) element per 4 cycles. ap_done must assert within 1,100,000 cycles of start.
- ap_done fires exactly once per run.

Decomposition:
- Shared package holds N, DATA_WID, BANKS, BANK_AW, the FSM state enum, and a function mapping (row,col) to (bank, bank address).
- One natural sub-module: floyd_bank_mux. It steers the per-cycle row-i/row-k requests onto the 8 bank ports and returns q to the datapath.

Test Plan:
- Reset: assert ap_rst mid-clock -> ap_idle=1 and all ce/we=0 before the next edge; ap_done stays 0 for 10 idle cycles.
- Chain graph:
  - Stimulus: diagonal 0, path[i][i+1]=1, all other entries 999; pulse start.
  - Expected: path[i][j]=j-i for j>=i; 999 for j<i; exactly one ap_done pulse, with ap_ready in the same cycle.
- Already optimal: diagonal 0, all other entries 5 -> matrix unchanged; the run still completes with one ap_done pulse.
- Negative weights:
  - Stimulus: diagonal 0, all other entries 1000, except path[0][1]=-5 and path[1][2]=-5.
  - Expected: path[0][2]=-10; path[2][1]=995; path[3][2]=990; path[0][5]=990; path[1][5]=995; path[4][7]=1000.
- Back-to-back runs: ap_start held high -> a second run starts on the cycle after DONE. Re-running on the chain-graph result leaves it unchanged.
- Reset mid-run:
  - Assert ap_rst 5000 cycles after start -> RAM activity stops immediately.
  - Then reload the chain graph and start -> correct result and a single ap_done pulse.

Source files
------------

// File: rtl/floyd_warshall_kernel_pkg.sv
// Shared types and constants for the banked Floyd-Warshall kernel.
// Maps a matrix (row, col) onto its row-block bank and in-bank address.
package floyd_warshall_kernel_pkg;

    localparam int N        = 64;
    localparam int DATA_WID = 32;
    localparam int BANKS    = 4;
    localparam int BANK_AW  = 10;
    localparam int BANK_SW  = $clog2(BANKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_IK,
        S_LD_IK,
        S_RD,
        S_CMP,
        S_WR,
        S_DONE
    } fw_state_e;

    typedef struct packed {
        logic [BANK_SW-1:0] bank;
        logic [BANK_AW-1:0] addr;
    } bank_loc_t;

    function automatic bank_loc_t map_rc(input int row, input int col, input int n);
        bank_loc_t loc;
        int        rows_per_bank;
        rows_per_bank = n / BANKS;
        loc.bank      = BANK_SW'(row / rows_per_bank);
        loc.addr      = BANK_AW'((row % rows_per_bank) * n + col);
        return loc;
    endfunction

endpackage

// File: rtl/floyd_bank_mux.sv
// Steers the row-i request (port 0) and row-k request (port 1) onto the bank RAM ports
// and returns the read data of both rows to the datapath.
module floyd_bank_mux
    import floyd_warshall_kernel_pkg::*;
(
    input  logic                i_ce_i,
    input  logic                i_we_i,
    input  bank_loc_t           i_loc_i,
    input  logic [DATA_WID-1:0] i_d_i,
    input  logic                i_ce_k,
    input  bank_loc_t           i_loc_k,
    input  logic [DATA_WID-1:0] i_q [BANKS][2],
    output logic [BANK_AW-1:0]  o_addr [BANKS][2],
    output logic                o_ce [BANKS][2],
    output logic                o_we [BANKS][2],
    output logic [DATA_WID-1:0] o_d [BANKS][2],
    output logic [DATA_WID-1:0] o_q_i,
    output logic [DATA_WID-1:0] o_q_k
);

    // Unselected ports are driven fully to zero so idle banks show no activity.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            o_ce[b][0]   = i_ce_i && (i_loc_i.bank == BANK_SW'(b));
            o_we[b][0]   = i_ce_i && i_we_i && (i_loc_i.bank == BANK_SW'(b));
            o_addr[b][0] = (i_ce_i && (i_loc_i.bank == BANK_SW'(b))) ? i_loc_i.addr : '0;
            o_d[b][0]    = (i_ce_i && i_we_i && (i_loc_i.bank == BANK_SW'(b))) ? i_d_i : '0;
            o_ce[b][1]   = i_ce_k && (i_loc_k.bank == BANK_SW'(b));
            o_we[b][1]   = 1'b0;
            o_addr[b][1] = (i_ce_k && (i_loc_k.bank == BANK_SW'(b))) ? i_loc_k.addr : '0;
            o_d[b][1]    = '0;
        end
    end

    assign o_q_i = i_q[i_loc_i.bank][0];
    assign o_q_k = i_q[i_loc_k.bank][1];

endmodule

// File: rtl/floyd_warshall_kernel.sv
// In-place Floyd-Warshall over an N x N signed matrix held in banked dual-port RAM.
// Each (i,j) element takes three cycles: read, compare, conditional write.
module floyd_warshall_kernel
    import floyd_warshall_kernel_pkg::*;
#(
    parameter int N = floyd_warshall_kernel_pkg::N
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    output logic [BANK_AW-1:0]  path_0_address0,
    output logic                path_0_ce0,
    output logic                path_0_we0,
    output logic [DATA_WID-1:0] path_0_d0,
    input  logic [DATA_WID-1:0] path_0_q0,
    output logic [BANK_AW-1:0]  path_0_address1,
    output logic                path_0_ce1,
    output logic                path_0_we1,
    output logic [DATA_WID-1:0] path_0_d1,
    input  logic [DATA_WID-1:0] path_0_q1,
    output logic [BANK_AW-1:0]  path_1_address0,
    output logic                path_1_ce0,
    output logic                path_1_we0,
    output logic [DATA_WID-1:0] path_1_d0,
    input  logic [DATA_WID-1:0] path_1_q0,
    output logic [BANK_AW-1:0]  path_1_address1,
    output logic                path_1_ce1,
    output logic                path_1_we1,
    output logic [DATA_WID-1:0] path_1_d1,
    input  logic [DATA_WID-1:0] path_1_q1,
    output logic [BANK_AW-1:0]  path_2_address0,
    output logic                path_2_ce0,
    output logic                path_2_we0,
    output logic [DATA_WID-1:0] path_2_d0,
    input  logic [DATA_WID-1:0] path_2_q0,
    output logic [BANK_AW-1:0]  path_2_address1,
    output logic                path_2_ce1,
    output logic                path_2_we1,
    output logic [DATA_WID-1:0] path_2_d1,
    input  logic [DATA_WID-1:0] path_2_q1,
    output logic [BANK_AW-1:0]  path_3_address0,
    output logic                path_3_ce0,
    output logic                path_3_we0,
    output logic [DATA_WID-1:0] path_3_d0,
    input  logic [DATA_WID-1:0] path_3_q0,
    output logic [BANK_AW-1:0]  path_3_address1,
    output logic                path_3_ce1,
    output logic                path_3_we1,
    output logic [DATA_WID-1:0] path_3_d1,
    input  logic [DATA_WID-1:0] path_3_q1
);

    localparam int              CW   = $clog2(N);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    fw_state_e           r_state;
    logic [CW-1:0]       r_k, r_i, r_j;
    logic [DATA_WID-1:0] r_ik, r_d;
    logic                r_ce_i, r_we_i, r_ce_k, r_fin, r_done, r_idle;
    bank_loc_t           r_loc_i, r_loc_k;

    logic [DATA_WID-1:0] w_q_i, w_q_k, w_s;
    logic                w_lt;
    bank_loc_t           w_loc_ik, w_loc_ij, w_loc_kj;
    logic [BANK_AW-1:0]  w_addr [BANKS][2];
    logic                w_ce [BANKS][2];
    logic                w_we [BANKS][2];
    logic [DATA_WID-1:0] w_d [BANKS][2];
    logic [DATA_WID-1:0] w_q [BANKS][2];

    assign w_loc_ik = map_rc(int'(r_i), int'(r_k), N);
    assign w_loc_ij = map_rc(int'(r_i), int'(r_j), N);
    assign w_loc_kj = map_rc(int'(r_k), int'(r_j), N);
    assign w_s      = r_ik + w_q_k;
    assign w_lt     = $signed(w_s) < $signed(w_q_i);

    // Block handshake: ap_start is sampled only in IDLE; ap_done and ap_ready pulse together
    // for the single DONE cycle; ap_idle is low from the accepting edge until DONE retires.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_ik    <= '0;
            r_d     <= '0;
            r_ce_i  <= 1'b0;
            r_we_i  <= 1'b0;
            r_ce_k  <= 1'b0;
            r_loc_i <= '0;
            r_loc_k <= '0;
            r_fin   <= 1'b0;
            r_done  <= 1'b0;
            r_idle  <= 1'b1;
        end else begin
            r_ce_i <= 1'b0;
            r_we_i <= 1'b0;
            r_ce_k <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_k     <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_fin   <= 1'b0;
                        r_idle  <= 1'b0;
                        r_ce_i  <= 1'b1;
                        r_loc_i <= map_rc(0, 0, N);
                        r_state <= S_RD_IK;
                    end
                end
                S_RD_IK: r_state <= S_LD_IK;
                S_LD_IK: begin
                    r_ik    <= w_q_i;
                    r_ce_i  <= 1'b1;
                    r_ce_k  <= 1'b1;
                    r_loc_i <= w_loc_ij;
                    r_loc_k <= w_loc_kj;
                    r_state <= S_RD;
                end
                S_RD: r_state <= S_CMP;
                S_CMP: begin
                    // Counters advance here so the next read address is ready when WR retires.
                    r_ce_i <= w_lt;
                    r_we_i <= w_lt;
                    r_d    <= w_s;
                    if (w_lt && (r_j == r_k)) begin
                        r_ik <= w_s;
                    end
                    r_j <= r_j + 1'b1;
                    if (r_j == LAST) begin
                        r_i <= r_i + 1'b1;
                        if (r_i == LAST) begin
                            r_k   <= r_k + 1'b1;
                            r_fin <= (r_k == LAST);
                        end
                    end
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (r_fin) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_j == '0) begin
                        r_ce_i  <= 1'b1;
                        r_loc_i <= w_loc_ik;
                        r_state <= S_RD_IK;
                    end else begin
                        r_ce_i  <= 1'b1;
                        r_ce_k  <= 1'b1;
                        r_loc_i <= w_loc_ij;
                        r_loc_k <= w_loc_kj;
                        r_state <= S_RD;
                    end
                end
                S_DONE: begin
                    r_idle  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ap_done  = r_done;
    assign ap_ready = r_done;
    assign ap_idle  = r_idle;

    floyd_bank_mux u_mux (
        .i_ce_i  (r_ce_i),
        .i_we_i  (r_we_i),
        .i_loc_i (r_loc_i),
        .i_d_i   (r_d),
        .i_ce_k  (r_ce_k),
        .i_loc_k (r_loc_k),
        .i_q     (w_q),
        .o_addr  (w_addr),
        .o_ce    (w_ce),
        .o_we    (w_we),
        .o_d     (w_d),
        .o_q_i   (w_q_i),
        .o_q_k   (w_q_k)
    );

    assign w_q[0][0] = path_0_q0;
    assign w_q[0][1] = path_0_q1;
    assign w_q[1][0] = path_1_q0;
    assign w_q[1][1] = path_1_q1;
    assign w_q[2][0] = path_2_q0;
    assign w_q[2][1] = path_2_q1;
    assign w_q[3][0] = path_3_q0;
    assign w_q[3][1] = path_3_q1;

    assign path_0_address0 = w_addr[0][0];
    assign path_0_ce0      = w_ce[0][0];
    assign path_0_we0      = w_we[0][0];
    assign path_0_d0       = w_d[0][0];
    assign path_0_address1 = w_addr[0][1];
    assign path_0_ce1      = w_ce[0][1];
    assign path_0_we1      = w_we[0][1];
    assign path_0_d1       = w_d[0][1];
    assign path_1_address0 = w_addr[1][0];
    assign path_1_ce0      = w_ce[1][0];
    assign path_1_we0      = w_we[1][0];
    assign path_1_d0       = w_d[1][0];
    assign path_1_address1 = w_addr[1][1];
    assign path_1_ce1      = w_ce[1][1];
    assign path_1_we1      = w_we[1][1];
    assign path_1_d1       = w_d[1][1];
    assign path_2_address0 = w_addr[2][0];
    assign path_2_ce0      = w_ce[2][0];
    assign path_2_we0      = w_we[2][0];
    assign path_2_d0       = w_d[2][0];
    assign path_2_address1 = w_addr[2][1];
    assign path_2_ce1      = w_ce[2][1];
    assign path_2_we1      = w_we[2][1];
    assign path_2_d1       = w_d[2][1];
    assign path_3_address0 = w_addr[3][0];
    assign path_3_ce0      = w_ce[3][0];
    assign path_3_we0      = w_we[3][0];
    assign path_3_d0       = w_d[3][0];
    assign path_3_address1 = w_addr[3][1];
    assign path_3_ce1      = w_ce[3][1];
    assign path_3_we1      = w_we[3][1];
    assign path_3_d1       = w_d[3][1];

endmodule

// File: tb/tb_floyd_warshall_kernel.sv
// Bench for floyd_warshall_kernel on a reduced 8x8 matrix: banked RAM model, host load port,
// and a plain triple-loop shortest-path reference feeding an expected-value queue.
module tb_floyd_warshall_kernel;

    localparam int N_TB       = 8;
    localparam int RPB        = N_TB / 4;
    localparam int RUN_BUDGET = N_TB * N_TB * N_TB * 4 + N_TB * N_TB * 12 + 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
    logic ap_done, ap_idle, ap_ready;
    logic [9:0]  ram_addr [4][2];
    logic        ram_ce [4][2];
    logic        ram_we [4][2];
    logic [31:0] ram_d [4][2];
    logic [31:0] ram_q [4][2];
    logic [31:0] mem [4][1024];

    logic        h_we;
    logic [1:0]  h_bank;
    logic [9:0]  h_addr;
    logic [31:0] h_data;

    logic signed [31:0] init_m [N_TB][N_TB];
    logic signed [31:0] exp_m [N_TB][N_TB];
    logic [31:0]        exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int rdy_mis  = 0;
    int rst_activity = 0;
    int d0;

    floyd_warshall_kernel #(.N(N_TB)) dut (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .path_0_address0(ram_addr[0][0]), .path_0_ce0(ram_ce[0][0]), .path_0_we0(ram_we[0][0]),
        .path_0_d0(ram_d[0][0]), .path_0_q0(ram_q[0][0]),
        .path_0_address1(ram_addr[0][1]), .path_0_ce1(ram_ce[0][1]), .path_0_we1(ram_we[0][1]),
        .path_0_d1(ram_d[0][1]), .path_0_q1(ram_q[0][1]),
        .path_1_address0(ram_addr[1][0]), .path_1_ce0(ram_ce[1][0]), .path_1_we0(ram_we[1][0]),
        .path_1_d0(ram_d[1][0]), .path_1_q0(ram_q[1][0]),
        .path_1_address1(ram_addr[1][1]), .path_1_ce1(ram_ce[1][1]), .path_1_we1(ram_we[1][1]),
        .path_1_d1(ram_d[1][1]), .path_1_q1(ram_q[1][1]),
        .path_2_address0(ram_addr[2][0]), .path_2_ce0(ram_ce[2][0]), .path_2_we0(ram_we[2][0]),
        .path_2_d0(ram_d[2][0]), .path_2_q0(ram_q[2][0]),
        .path_2_address1(ram_addr[2][1]), .path_2_ce1(ram_ce[2][1]), .path_2_we1(ram_we[2][1]),
        .path_2_d1(ram_d[2][1]), .path_2_q1(ram_q[2][1]),
        .path_3_address0(ram_addr[3][0]), .path_3_ce0(ram_ce[3][0]), .path_3_we0(ram_we[3][0]),
        .path_3_d0(ram_d[3][0]), .path_3_q0(ram_q[3][0]),
        .path_3_address1(ram_addr[3][1]), .path_3_ce1(ram_ce[3][1]), .path_3_we1(ram_we[3][1]),
        .path_3_d1(ram_d[3][1]), .path_3_q1(ram_q[3][1])
    );

    function automatic int active_ports();
        int n;
        n = 0;
        for (int b = 0; b < 4; b++)
            for (int p = 0; p < 2; p++)
                n += int'(ram_ce[b][p]) + int'(ram_we[b][p]);
        return n;
    endfunction

    function automatic logic [31:0] mem_rd(input int i, input int j);
        return mem[2'(i / RPB)][10'((i % RPB) * N_TB + j)];
    endfunction

    // Banked RAM: reads return pre-edge contents, writes commit at the edge.
    always @(posedge clk) begin
        if (h_we) mem[h_bank][h_addr] <= h_data;
        for (int b = 0; b < 4; b++)
            for (int p = 0; p < 2; p++) begin
                if (ram_ce[b][p] && !ram_we[b][p]) ram_q[b][p] <= mem[b][ram_addr[b][p]];
                if (ram_ce[b][p] && ram_we[b][p]) mem[b][ram_addr[b][p]] <= ram_d[b][p];
            end
        if (rst && active_ports() != 0) rst_activity <= rst_activity + 1;
    end

    always @(negedge clk) begin
        if (ap_done) done_cnt++;
        if (ap_done !== ap_ready) rdy_mis++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(want));
        end
    endtask

    task automatic load_matrix();
        for (int i = 0; i < N_TB; i++)
            for (int j = 0; j < N_TB; j++) begin
                @(negedge clk);
                h_we   = 1'b1;
                h_bank = 2'(i / RPB);
                h_addr = 10'((i % RPB) * N_TB + j);
                h_data = init_m[i][j];
            end
        @(negedge clk);
        h_we = 1'b0;
    endtask

    task automatic prepare_expected();
        for (int i = 0; i < N_TB; i++)
            for (int j = 0; j < N_TB; j++)
                exp_m[i][j] = init_m[i][j];
        for (int k = 0; k < N_TB; k++)
            for (int i = 0; i < N_TB; i++)
                for (int j = 0; j < N_TB; j++) begin
                    logic signed [31:0] s;
                    s = exp_m[i][k] + exp_m[k][j];
                    if (s < exp_m[i][j]) exp_m[i][j] = s;
                end
    endtask

    task automatic compare_matrix(input string tag);
        for (int i = 0; i < N_TB; i++)
            for (int j = 0; j < N_TB; j++)
                exp_q.push_back(exp_m[i][j]);
        for (int i = 0; i < N_TB; i++)
            for (int j = 0; j < N_TB; j++) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check($sformatf("%s[%0d][%0d]", tag, i, j), mem_rd(i, j), e);
            end
    endtask

    task automatic wait_done(input string tag);
        int  cyc;
        bit  seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < RUN_BUDGET) begin
            @(negedge clk);
            cyc++;
            if (ap_done) seen = 1'b1;
        end
        check({tag, "_done_in_budget"}, 32'(seen), 32'd1);
        if (seen) check({tag, "_ready_with_done"}, 32'(ap_ready), 32'd1);
    endtask

    task automatic do_run(input string tag);
        int base;
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag);
        repeat (10) @(negedge clk);
        check({tag, "_done_once"}, 32'(done_cnt - base), 32'd1);
        check({tag, "_idle_after"}, 32'(ap_idle), 32'd1);
    endtask

    task automatic set_chain();
        for (int i = 0; i < N_TB; i++)
            for (int j = 0; j < N_TB; j++)
                init_m[i][j] = (i == j) ? 0 : ((j == i + 1) ? 1 : 999);
    endtask

    task automatic set_random();
        for (int i = 0; i < N_TB; i++)
            for (int j = 0; j < N_TB; j++) begin
                int r;
                int v;
                r = int'($urandom_range(0, 9));
                v = int'($urandom_range(0, 400)) - 50;
                if (i == j) init_m[i][j] = (r == 0) ? -int'($urandom_range(1, 3)) : 0;
                else if (r == 1) init_m[i][j] = 32'h7fff_ff00;
                else init_m[i][j] = v;
            end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        h_we = 1'b0; h_bank = '0; h_addr = '0; h_data = '0;
        repeat (2) @(negedge clk);
        check("rst_idle", 32'(ap_idle), 32'd1);
        check("rst_done", 32'(ap_done), 32'd0);
        check("rst_ready", 32'(ap_ready), 32'd0);
        check("rst_ports", active_ports(), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_no_done", done_cnt, 0);
        check("idle_held", 32'(ap_idle), 32'd1);

        set_chain(); load_matrix(); prepare_expected();
        do_run("chain");
        compare_matrix("chain");
        check("chain_0_7", mem_rd(0, 7), 7);
        check("chain_2_6", mem_rd(2, 6), 4);
        check("chain_5_2", mem_rd(5, 2), 999);

        for (int i = 0; i < N_TB; i++)
            for (int j = 0; j < N_TB; j++)
                init_m[i][j] = (i == j) ? 0 : 5;
        load_matrix(); prepare_expected();
        do_run("optimal");
        compare_matrix("optimal");
        check("optimal_3_4", mem_rd(3, 4), 5);

        for (int i = 0; i < N_TB; i++)
            for (int j = 0; j < N_TB; j++)
                init_m[i][j] = (i == j) ? 0 : 1000;
        init_m[0][1] = -5;
        init_m[1][2] = -5;
        load_matrix(); prepare_expected();
        do_run("neg");
        compare_matrix("neg");
        check("neg_0_2", mem_rd(0, 2), -10);
        check("neg_2_1", mem_rd(2, 1), 995);
        check("neg_3_2", mem_rd(3, 2), 990);
        check("neg_0_5", mem_rd(0, 5), 990);
        check("neg_1_5", mem_rd(1, 5), 995);
        check("neg_4_7", mem_rd(4, 7), 1000);

        set_chain(); load_matrix(); prepare_expected();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        wait_done("b2b_first");
        @(negedge clk);
        @(negedge clk);
        check("b2b_restarted", 32'(ap_idle), 32'd0);
        start = 1'b0;
        wait_done("b2b_second");
        repeat (10) @(negedge clk);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        compare_matrix("b2b");
        check("b2b_1_6", mem_rd(1, 6), 5);

        set_chain(); load_matrix(); prepare_expected();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        check("midrst_running", 32'(ap_idle), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ports", active_ports(), 0);
        check("midrst_idle", 32'(ap_idle), 32'd1);
        check("midrst_done", 32'(ap_done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("midrst_no_activity", rst_activity, 0);
        repeat (5) @(negedge clk);
        check("midrst_quiet", active_ports(), 0);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        load_matrix(); prepare_expected();
        do_run("post_rst");
        compare_matrix("post_rst");

        for (int t = 0; t < 4; t++) begin
            set_random(); load_matrix(); prepare_expected();
            do_run($sformatf("rand%0d", t));
            compare_matrix($sformatf("rand%0d", t));
        end

        check("ready_tracks_done", rdy_mis, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
